// File: rtl/edf_pkg.sv
// Shared types and helpers for the EDF arbiter: FSM states, index width and
// wrap-safe timestamp ordering.
package edf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } edf_state_t;

    // Widest timestamp the ordering helper supports.
    localparam int TS_MAX_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a is earlier than b when (a - b) mod 2^w has its sign bit set.
    function automatic logic ts_earlier(
        input logic [TS_MAX_W-1:0] a,
        input logic [TS_MAX_W-1:0] b,
        input int                  w
    );
        logic [TS_MAX_W-1:0] diff;
        diff = a - b;
        return diff[w-1];
    endfunction

endpackage

// File: rtl/edf_min_select.sv
// Combinational minimum-deadline selection over the pending requesters.
// Equal deadlines resolve to the lower index.
module edf_min_select
    import edf_pkg::*;
#(
    parameter int  N     = 4,
    parameter int  TS_W  = 16,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]           pending,
    input  logic [N-1:0][TS_W-1:0] deadline,
    output logic [IDX_W-1:0]       winner,
    output logic                   found
);

    localparam int LEAVES = 1 << IDX_W;
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap-ordered tree: node k has children 2k+1 (lower indices) and 2k+2.
    logic             node_v   [NODES];
    logic [IDX_W-1:0] node_idx [NODES];
    logic [TS_W-1:0]  node_dl  [NODES];

    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            node_v[k]   = 1'b0;
            node_idx[k] = '0;
            node_dl[k]  = '0;
        end
        for (int i = 0; i < N; i++) begin
            node_v[LEAVES-1+i]   = pending[i];
            node_idx[LEAVES-1+i] = IDX_W'(i);
            node_dl[LEAVES-1+i]  = deadline[i];
        end
        // The right child only wins when strictly earlier, keeping ties on the left.
        for (int k = LEAVES - 2; k >= 0; k--) begin
            if (node_v[2*k+2] &&
                (!node_v[2*k+1] ||
                 ts_earlier(TS_MAX_W'(node_dl[2*k+2]), TS_MAX_W'(node_dl[2*k+1]), TS_W))) begin
                node_v[k]   = 1'b1;
                node_idx[k] = node_idx[2*k+2];
                node_dl[k]  = node_dl[2*k+2];
            end else begin
                node_v[k]   = node_v[2*k+1];
                node_idx[k] = node_idx[2*k+1];
                node_dl[k]  = node_dl[2*k+1];
            end
        end
        winner = node_idx[0];
        found  = node_v[0];
    end

endmodule

// File: rtl/edf_axi_arbiter.sv
// Earliest-Deadline-First arbiter sharing one downstream AXI master between N
// requesters; non-preemptive, grant held until txn_done.
module edf_axi_arbiter
    import edf_pkg::*;
#(
    parameter int  N          = 4,
    parameter int  TS_W       = 16,
    parameter int  DEF_PERIOD = 100,
    parameter int  CNT_W      = 16,
    localparam int IDX_W      = idx_width(N)
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_id,
    input  logic             txn_done,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [TS_W-1:0]  cfg_period,
    output logic             miss_pulse,
    output logic [CNT_W-1:0] miss_count
);

    edf_state_t             state;
    edf_state_t             state_nxt;
    logic [TS_W-1:0]        now;
    logic [N-1:0]           pending;
    logic [N-1:0][TS_W-1:0] deadline;
    logic [N-1:0][TS_W-1:0] period;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    logic                   winner_late;
    logic                   do_grant;
    logic                   do_release;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign req_ready = ~pending;

    edf_min_select #(
        .N    (N),
        .TS_W (TS_W)
    ) u_min_select (
        .pending  (pending),
        .deadline (deadline),
        .winner   (winner),
        .found    (found)
    );

    assign winner_late = ts_earlier(TS_MAX_W'(deadline[winner]), TS_MAX_W'(now), TS_W);

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        unique case (state)
            IDLE: if (|pending) state_nxt = ARB;
            ARB: begin
                if (found) begin
                    state_nxt = BUSY;
                    do_grant  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (txn_done) begin
                    state_nxt  = IDLE;
                    do_release = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            now   <= '0;
        end else begin
            state <= state_nxt;
            now   <= now + 1'b1;
        end
    end

    // Capture uses the period value from before any same-cycle config write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending  <= '0;
            deadline <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pending[i]  <= 1'b1;
                    deadline[i] <= now + period[i];
                end else if (do_release && (grant_id == IDX_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < N; i++) period[i] <= TS_W'(DEF_PERIOD);
        end else if (cfg_we && (int'(cfg_idx) < N)) begin
            period[cfg_idx] <= cfg_period;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            miss_pulse  <= 1'b0;
            miss_count  <= '0;
        end else begin
            miss_pulse <= 1'b0;
            if (do_grant) begin
                grant_valid <= 1'b1;
                grant_id    <= winner;
                if (winner_late) begin
                    miss_pulse <= 1'b1;
                    miss_count <= sat_inc(miss_count);
                end
            end else if (do_release) begin
                grant_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edf_axi_arbiter.sv
// Self-checking bench for edf_axi_arbiter: directed scenarios plus random
// traffic compared against a transaction-level EDF reference model.
module tb_edf_axi_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       txn_done;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_period;
    logic       miss_pulse;
    logic [1:0] miss_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_now;
    bit m_pend [4];
    int m_dl   [4];
    int m_per  [4];
    bit m_gv;
    int m_gid;
    bit m_arb;
    bit m_miss;
    int m_mcnt;

    edf_axi_arbiter #(
        .N          (4),
        .TS_W       (8),
        .DEF_PERIOD (100),
        .CNT_W      (2)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .txn_done    (txn_done),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_period  (cfg_period),
        .miss_pulse  (miss_pulse),
        .miss_count  (miss_count)
    );

    always #5 ACLK = ~ACLK;

    function automatic bit earlier(input int a, input int b);
        return ((a - b) & 255) >= 128;
    endfunction

    task automatic model_reset();
        m_now = 0; m_gv = 0; m_gid = 0; m_arb = 0; m_miss = 0; m_mcnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_dl[i] = 0; m_per[i] = 100;
        end
    endtask

    // One clock: model applies the rules to the inputs seen at the edge.
    task automatic step();
        int  win;
        int  rel;
        bit  any;
        @(posedge ACLK);
        win = -1; any = 0; rel = -1;
        for (int i = 0; i < 4; i++)
            if (m_pend[i]) begin
                any = 1;
                if (win < 0 || earlier(m_dl[i], m_dl[win])) win = i;
            end
        m_miss = 0;
        if (m_arb) begin
            m_arb = 0; m_gv = 1; m_gid = win;
            if (earlier(m_dl[win], m_now)) begin
                m_miss = 1;
                if (m_mcnt < 3) m_mcnt++;
            end
        end else if (m_gv) begin
            if (txn_done) begin rel = m_gid; m_gv = 0; end
        end else if (any) begin
            m_arb = 1;
        end
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && !m_pend[i]) begin
                m_pend[i] = 1; m_dl[i] = (m_now + m_per[i]) & 255;
            end
        if (rel >= 0) m_pend[rel] = 0;
        if (cfg_we) m_per[cfg_idx] = int'(cfg_period);
        m_now = (m_now + 1) & 255;
        @(negedge ACLK);
    endtask

    task automatic set_period(input int idx, input int p);
        cfg_we = 1; cfg_idx = 2'(idx); cfg_period = 8'(p);
        step();
        cfg_we = 0;
    endtask

    task automatic idle_until(input int t);
        int n = 0;
        while (m_now != t && n < 300) begin step(); n++; end
        if (m_now != t) begin errors++; $display("FAIL idle_until: now %0d want %0d", m_now, t); end
    endtask

    task automatic wait_model_grant();
        int n = 0;
        while (!m_gv && n < 10) begin step(); n++; end
        if (!m_gv) begin errors++; $display("FAIL grant_timeout: no grant within 10 cycles"); end
    endtask

    task automatic test_reset();
        ARESETN = 0; req_valid = 0; txn_done = 0; cfg_we = 0; cfg_idx = 0; cfg_period = 0;
        model_reset();
        repeat (3) @(negedge ACLK);
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_gv: got %0b want 0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
        checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL rst_miss: got %0b want 0", miss_pulse); end
        checks++; if (miss_count !== 2'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", miss_count); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL rst_ready: got %b want 1111", req_ready); end
        ARESETN = 1;
        step();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: got %0b want 0", grant_valid); end
    endtask

    task automatic test_single();
        set_period(2, 10);
        idle_until(5);
        req_valid = 4'b0100; step(); req_valid = 0;
        checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL single_ready0: got %0b want 0", req_ready[2]); end
        step();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_arb: got %0b want 0", grant_valid); end
        step();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL single_gv: got %0b want 1", grant_valid); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid: got %0d want 2", grant_id); end
        checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL single_miss: got %0b want 0", miss_pulse); end
        repeat (2) step();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL single_hold: got %0b/%0d want 1/2", grant_valid, grant_id); end
        txn_done = 1; step(); txn_done = 0;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %0b want 0", grant_valid); end
        checks++; if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready1: got %0b want 1", req_ready[2]); end
        txn_done = 1; step(); txn_done = 0;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got %0b want 0", grant_valid); end
    endtask

    task automatic run_order(input string name, input logic [3:0] reqs, input int exp_n,
                             input int e0, input int e1, input int e2, input int e3);
        int exp_ids [4];
        exp_ids[0] = e0; exp_ids[1] = e1; exp_ids[2] = e2; exp_ids[3] = e3;
        req_valid = reqs; step(); req_valid = 0;
        for (int k = 0; k < exp_n; k++) begin
            wait_model_grant();
            checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL %s_gv%0d: got %0b want 1", name, k, grant_valid); end
            checks++; if (int'(grant_id) != exp_ids[k] || int'(grant_id) != m_gid) begin
                errors++; $display("FAIL %s_gid%0d: got %0d want %0d", name, k, grant_id, exp_ids[k]);
            end
            repeat (2) step();
            txn_done = 1; step(); txn_done = 0;
        end
    endtask

    task automatic test_edf_order();
        set_period(0, 100); set_period(1, 20); set_period(2, 50); set_period(3, 80);
        run_order("edf", 4'b1111, 4, 1, 2, 3, 0);
    endtask

    task automatic test_tie();
        set_period(0, 30); set_period(3, 30);
        run_order("tie", 4'b1001, 2, 0, 3, 0, 0);
    endtask

    task automatic test_wrap();
        set_period(0, 8'h20); set_period(1, 8'h0A);
        idle_until(8'hF0);
        run_order("wrap", 4'b0011, 2, 1, 0, 0, 0);
    endtask

    task automatic test_cfg_same_cycle();
        set_period(2, 10); set_period(3, 20);
        cfg_we = 1; cfg_idx = 2; cfg_period = 100;
        run_order("cfgold", 4'b1100, 2, 2, 3, 0, 0);
    endtask

    task automatic test_miss();
        int exp_cnt [4];
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3;
        set_period(0, 100); set_period(1, 3);
        for (int r = 0; r < 4; r++) begin
            req_valid = 4'b0001; step(); req_valid = 0;
            wait_model_grant();
            req_valid = 4'b0010; step(); req_valid = 0;
            repeat (10) step();
            txn_done = 1; step(); txn_done = 0;
            wait_model_grant();
            checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL miss_gid%0d: got %0d want 1", r, grant_id); end
            checks++; if (miss_pulse !== 1'b1) begin errors++; $display("FAIL miss_pulse%0d: got %0b want 1", r, miss_pulse); end
            checks++; if (int'(miss_count) != exp_cnt[r] || int'(miss_count) != m_mcnt) begin
                errors++; $display("FAIL miss_count%0d: got %0d want %0d", r, miss_count, exp_cnt[r]);
            end
            step();
            checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_one_cycle%0d: got %0b want 0", r, miss_pulse); end
            txn_done = 1; step(); txn_done = 0;
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) set_period(i, $urandom_range(1, 60));
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) req_valid[i] = ($urandom_range(0, 3) == 0);
            txn_done = ($urandom_range(0, 1) == 1);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(1, 60));
            step();
            for (int i = 0; i < 4; i++) exp_ready[i] = !m_pend[i];
            checks++; if (grant_valid !== m_gv) begin errors++; $display("FAIL rnd_gv c%0d: got %0b want %0b", c, grant_valid, m_gv); end
            if (m_gv) begin
                checks++; if (int'(grant_id) != m_gid) begin errors++; $display("FAIL rnd_gid c%0d: got %0d want %0d", c, grant_id, m_gid); end
            end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
            checks++; if (miss_pulse !== m_miss) begin errors++; $display("FAIL rnd_miss c%0d: got %0b want %0b", c, miss_pulse, m_miss); end
            checks++; if (int'(miss_count) != m_mcnt) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, miss_count, m_mcnt); end
        end
        req_valid = 0; cfg_we = 0; txn_done = 1;
        repeat (12) step();
        txn_done = 0;
    endtask

    task automatic test_reset_busy();
        set_period(0, 90); set_period(1, 5);
        req_valid = 4'b0001; step(); req_valid = 0;
        wait_model_grant();
        req_valid = 4'b0010; step(); req_valid = 0;
        #2 ARESETN = 0;
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rb_gv: got %0b want 0", grant_valid); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL rb_pending: got %b want 1111", req_ready); end
        checks++; if (miss_count !== 2'd0) begin errors++; $display("FAIL rb_cnt: got %0d want 0", miss_count); end
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        run_order("rb_defper", 4'b0011, 2, 0, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_edf_order();
        test_tie();
        test_wrap();
        test_cfg_same_cycle();
        test_miss();
        test_random();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edf_axi_arbiter.md
Name: edf_axi_arbiter

Overview:
- Earliest-Deadline-First scheduler that shares one downstream AXI master port (Bit_Dropper datapath / memory path) between N requesters.
- Each requester raises a request. The block timestamps it with an absolute deadline of now + period[i], grants the pending request with the earliest deadline, and holds that grant until the downstream transaction completes.
- Sits between the per-core request front-ends and the AXI mux/datapath, which it steers through grant_id.

Parameters:
- N, 4, number of requesters (2..16)
- TS_W, 16, width of timestamp, period and deadline values
- DEF_PERIOD, 100, reset value of every period register (cycles)
- CNT_W, 16, width of deadline-miss counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester request
- req_ready  out  N  per-requester accept; req_ready[i] = ~pending[i]
- grant_valid  out  1  a grant is active
- grant_id  out  clog2(N)  index of granted requester; stable while grant_valid
- txn_done  in  1  one-cycle pulse when the granted transaction finishes (B or last R beat)
- cfg_we  in  1  period register write strobe
- cfg_idx  in  clog2(N)  period register index
- cfg_period  in  TS_W  relative deadline in cycles
- miss_pulse  out  1  one-cycle pulse: granted request was already past its deadline
- miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Reset (async, ARESETN=0) forces:
  - now=0, pending=0, state=IDLE
  - grant_valid=0, grant_id=0
  - miss_pulse=0, miss_count=0
  - all period[i]=DEF_PERIOD, all deadline[i]=0
- now: free-running TS_W counter, +1 every cycle, wraps mod 2^TS_W.
- Capture: req_valid[i] & req_ready[i] at an edge sets pending[i]=1 and deadline[i]=(now+period[i]) mod 2^TS_W. All requesters are captured independently in the same cycle.
- Ordering: a is earlier than b iff (a-b) interpreted as signed TS_W is negative. This is wrap-safe provided every period < 2^(TS_W-1); larger periods give undefined ordering.
- FSM:
  - IDLE: if pending≠0 → ARB; else stay.
  - ARB (1 cycle): winner = pending index with the earliest deadline; ties go to the lowest index. On the next edge: grant_id=winner, grant_valid=1, → BUSY. If deadline[winner] is earlier than now, miss_pulse=1 for that cycle and miss_count increments, saturating at all-ones.
  - BUSY: on txn_done=1 → pending[grant_id]=0, grant_valid=0, → IDLE.
- Grant latency: request accepted at edge E0 → ARB after E1 → grant_valid=1 after E2. Back-to-back: done at edge D0, next grant after D2.
- Non-preemptive: a request arriving with an earlier deadline during BUSY waits for the next ARB.
- txn_done in IDLE or ARB is ignored.
- Granted requester: req_ready stays 0 until the cycle after its done, so it can re-request 1 cycle after done.
- Config:
  - cfg_we writes period[cfg_idx] at the edge.
  - A capture in the same cycle uses the old period.
  - cfg_idx ≥ N is ignored.
  - Existing deadlines are not recomputed.
- Reset mid-BUSY drops all pending requests and the grant. The downstream is responsible for its own AXI abort.

Decomposition:
- Package edf_pkg: state enum (IDLE, ARB, BUSY), the function ts_earlier(a,b) for wrap-safe compare, and the clog2-based index width helper.
- One sub-module, edf_min_select: combinational tree over pending/deadline producing winner index and a found flag, with lowest-index tie-break. The top holds the FSM, registers and counters.

Test Plan:
- Single request: period[2]=10, pulse req_valid[2] at now=5 → deadline[2]=15, grant_id=2 two cycles later; txn_done → grant_valid=0, req_ready[2]=1 next cycle.
- EDF order: periods {100,20,50,80}, all four requests accepted in the same cycle → grants in order 1,2,3,0, each after the prior txn_done.
- Tie: periods[0]=periods[3]=30, simultaneous requests → grant 0 first, then 3.
- Wrap-around: force now=0xFFF0, period=0x20 → deadline=0x0010; compete with a deadline of 0xFFFA → the 0xFFFA requester wins.
- Deadline miss: period=3, hold BUSY 10 cycles on another requester → when the late one is granted, miss_pulse for exactly 1 cycle and miss_count=1. Repeat to saturation with CNT_W=2 → miss_count holds at 3.
- Reset mid-BUSY: drop ARESETN while grant_valid=1 → grant_valid, pending and miss_count go to 0 immediately (asynchronously); after release, period registers read DEF_PERIOD.
